// File: rtl/spike_rate_decoder_pkg.sv
// Shared types and defaults for the spike rate decoder.
package spike_dec_pkg;
  typedef enum logic {IDLE, COUNT} state_t;

  localparam int unsigned RATE_W_DEF = 8;
  localparam int unsigned ISI_W_DEF  = 16;

  localparam logic [RATE_W_DEF-1:0] RATE_MAX_DEF = '1;
  localparam logic [ISI_W_DEF-1:0]  ISI_MAX_DEF  = '1;
endpackage

// File: rtl/spike_rate_decoder_if.sv
// Spike input / rate output bundle between the neuron wrapper and the decoder.
interface spike_rate_decoder_if #(
  parameter int unsigned RATE_W = spike_dec_pkg::RATE_W_DEF,
  parameter int unsigned ISI_W  = spike_dec_pkg::ISI_W_DEF
);
  logic              ena;
  logic              spike_in;
  logic [RATE_W-1:0] rate;
  logic              rate_valid;
  logic              overflow;
  logic [ISI_W-1:0]  isi;
  logic              isi_valid;

  modport master (output ena, spike_in,
                  input  rate, rate_valid, overflow, isi, isi_valid);
  modport slave  (input  ena, spike_in,
                  output rate, rate_valid, overflow, isi, isi_valid);
endinterface

// File: rtl/spike_rate_decoder_edge_detect.sv
// Rising-edge detector on the spike level; the register runs regardless of enable.
module spike_edge_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic spike_in,
  output logic spike_edge
);
  logic spike_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) spike_q <= 1'b0;
    else        spike_q <= spike_in;
  end

  assign spike_edge = spike_in & ~spike_q;
endmodule

// File: rtl/spike_rate_decoder.sv
// Counts spike rising edges per window and publishes an 8-bit rate strobe.
// Optional inter-spike-interval measurement enabled by SPIKE_DEC_ISI_EN.
module spike_rate_decoder
  import spike_dec_pkg::*;
#(
  parameter logic [23:0] WINDOW_CYCLES = 24'd10_000_000,
  parameter int unsigned RATE_W        = RATE_W_DEF,
  parameter int unsigned ISI_W         = ISI_W_DEF
) (
  input logic                 clk,
  input logic                 rst_n,
  spike_rate_decoder_if.slave bus
);
  localparam logic [RATE_W-1:0] SPK_MAX  = '1;
  localparam logic [23:0]       WIN_LAST = WINDOW_CYCLES - 24'd1;

  state_t            state;
  logic [23:0]       win_cnt;
  logic [RATE_W-1:0] spk_cnt, spk_next;
  logic              ovf_flag, ovf_next;
  logic [RATE_W-1:0] rate_r;
  logic              rate_valid_r, overflow_r;
  logic              spike_edge;
`ifdef SPIKE_DEC_ISI_EN
  localparam logic [ISI_W-1:0] ISI_MAX = '1;
  logic [ISI_W-1:0] isi_cnt, isi_r;
  logic             isi_armed, isi_valid_r;
`endif

  spike_edge_detect u_edge (
    .clk       (clk),
    .rst_n     (rst_n),
    .spike_in  (bus.spike_in),
    .spike_edge(spike_edge)
  );

  always_comb begin
    spk_next = spk_cnt;
    ovf_next = ovf_flag;
    if (spike_edge) begin
      if (spk_cnt == SPK_MAX) ovf_next = 1'b1;
      else                    spk_next = spk_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      win_cnt      <= '0;
      spk_cnt      <= '0;
      ovf_flag     <= 1'b0;
      rate_r       <= '0;
      overflow_r   <= 1'b0;
      rate_valid_r <= 1'b0;
`ifdef SPIKE_DEC_ISI_EN
      isi_cnt      <= '0;
      isi_r        <= '0;
      isi_armed    <= 1'b0;
      isi_valid_r  <= 1'b0;
`endif
    end else begin
      rate_valid_r <= 1'b0;
`ifdef SPIKE_DEC_ISI_EN
      isi_valid_r  <= 1'b0;
`endif
      case (state)
        IDLE: begin
          win_cnt  <= '0;
          spk_cnt  <= '0;
          ovf_flag <= 1'b0;
`ifdef SPIKE_DEC_ISI_EN
          isi_cnt   <= '0;
          isi_armed <= 1'b0;
`endif
          // The ena-rise cycle is already window cycle 0, so it counts its edge.
          if (bus.ena) begin
            state   <= COUNT;
            win_cnt <= 24'd1;
            spk_cnt <= spike_edge ? RATE_W'(1) : '0;
`ifdef SPIKE_DEC_ISI_EN
            if (spike_edge) begin
              isi_armed <= 1'b1;
              isi_cnt   <= ISI_W'(1);
            end
`endif
          end
        end
        COUNT: begin
          if (!bus.ena) begin
            state    <= IDLE;
            win_cnt  <= '0;
            spk_cnt  <= '0;
            ovf_flag <= 1'b0;
          end else if (win_cnt == WIN_LAST) begin
            rate_r       <= spk_next;
            overflow_r   <= ovf_next;
            rate_valid_r <= 1'b1;
            win_cnt      <= '0;
            spk_cnt      <= '0;
            ovf_flag     <= 1'b0;
          end else begin
            win_cnt  <= win_cnt + 24'd1;
            spk_cnt  <= spk_next;
            ovf_flag <= ovf_next;
          end
`ifdef SPIKE_DEC_ISI_EN
          if (!bus.ena) begin
            isi_cnt   <= '0;
            isi_armed <= 1'b0;
          end else if (spike_edge) begin
            isi_cnt   <= ISI_W'(1);
            isi_armed <= 1'b1;
            if (isi_armed) begin
              isi_r       <= isi_cnt;
              isi_valid_r <= 1'b1;
            end
          end else if (isi_cnt != ISI_MAX) begin
            isi_cnt <= isi_cnt + 1'b1;
          end
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.rate       = rate_r;
  assign bus.rate_valid = rate_valid_r;
  assign bus.overflow   = overflow_r;
`ifdef SPIKE_DEC_ISI_EN
  assign bus.isi        = isi_r;
  assign bus.isi_valid  = isi_valid_r;
`else
  assign bus.isi        = '0;
  assign bus.isi_valid  = 1'b0;
`endif
endmodule
